// File: rtl/osc_freq_meter.sv
// osc_freq_meter
//   Measures a divided ring-oscillator by counting its synchronized edges over
//   a fixed window of clk cycles, then holds the count until it is accepted.
//   After acceptance the next measurement starts automatically.
//
//   Optional build macro: OSC_FREQ_METER_BOTH_EDGES_EN
//     undefined : count rising synced edges only
//     defined   : count rising and falling synced edges
//
// Parameters
//   CNT_W        width of edge counter and result
//   SYNC_STAGES  osc_in synchronizer depth (2..4)
//
// Ports
//   clk           sole clock, rising edge
//   reset_n       synchronous active-low reset
//   ena           block enable; low forces IDLE and drops any partial count
//   osc_in        asynchronous oscillator input
//   gate_sel      window: 0=256, 1=1024, 2=4096, 3=16384 clk cycles
//   result        edges counted in the last completed window
//   result_valid  result awaiting acceptance
//   result_ready  consumer accepts result when high with result_valid
//   saturated     last completed window hit the counter ceiling
//   busy          high in ARM or GATE
module osc_freq_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ena,
    input  logic             osc_in,
    input  logic [1:0]       gate_sel,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             saturated,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [13:0]      ARM_LAST = 14'(SYNC_STAGES);

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               hist_q;
    logic               synced;
    logic               osc_edge;
    logic [13:0]        tmr_q;
    logic [13:0]        win_last;
    logic [1:0]         sel_q;
    logic [CNT_W-1:0]   cnt_q, cnt_nx;
    logic               sat_q, sat_nx;
    logic               arm_done, gate_done;

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef OSC_FREQ_METER_BOTH_EDGES_EN
    assign osc_edge = synced ^ hist_q;
`else
    assign osc_edge = synced & ~hist_q;
`endif

    always_comb begin
        win_last = 14'd255;
        case (sel_q)
            2'd0:    win_last = 14'd255;
            2'd1:    win_last = 14'd1023;
            2'd2:    win_last = 14'd4095;
            default: win_last = 14'd16383;
        endcase
    end

    assign arm_done  = (state_q == ARM)  && (tmr_q == ARM_LAST);
    assign gate_done = (state_q == GATE) && (tmr_q == win_last);

    // Counter sticks at the ceiling; an edge arriving there flags saturation.
    assign cnt_nx = (osc_edge && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
    assign sat_nx = sat_q | (osc_edge && cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ena) state_d = ARM;
            ARM:  if (arm_done) state_d = GATE;
            GATE: if (gate_done) state_d = HOLD;
            HOLD: if (result_valid && result_ready) state_d = ARM;
            default: state_d = IDLE;
        endcase
        // Disable wins over everything, including a same-cycle acceptance.
        if (!ena) state_d = IDLE;
    end

    assign busy = (state_q == ARM) || (state_q == GATE);

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q       <= '0;
            hist_q       <= 1'b0;
            tmr_q        <= '0;
            sel_q        <= '0;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            result       <= '0;
            saturated    <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            hist_q <= synced;

            if ((state_q == ARM || state_q == GATE) && state_d == state_q)
                tmr_q <= tmr_q + 1'b1;
            else
                tmr_q <= '0;

            if (arm_done)
                sel_q <= gate_sel;

            // Count only while staying in GATE; the final GATE cycle's edge
            // is folded in through cnt_nx when the result is loaded.
            if (state_q == GATE && state_d == GATE) begin
                cnt_q <= cnt_nx;
                sat_q <= sat_nx;
            end else begin
                cnt_q <= '0;
                sat_q <= 1'b0;
            end

            if (state_q == GATE && state_d == HOLD) begin
                result    <= cnt_nx;
                saturated <= sat_nx;
            end

            if (!ena)
                result_valid <= 1'b0;
            else if (state_q == GATE && state_d == HOLD)
                result_valid <= 1'b1;
            else if (state_q == HOLD && result_ready)
                result_valid <= 1'b0;
        end
    end

endmodule
